// File: rtl/sram_wb_port.sv
// Wishbone classic 16-bit slave bridged onto the SDRAM controller's edge-strobed request port.
// Optional macro SRAM_WB_POST_WRITE_EN: writes ack at acceptance and finish in the background.

module sram_wb_port #(
  parameter int GUARD_CYCLES = 2,
  parameter int TIMEOUT      = 1023
) (
  input  logic        clk,
  input  logic        init,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_sel_i,
  input  logic [23:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [24:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [1:0]  mem_wtbt,
  output logic        mem_we,
  output logic        mem_rd,
  input  logic [15:0] mem_dout,
  input  logic        mem_ready
);

`ifdef SRAM_WB_POST_WRITE_EN
  localparam bit POST_WRITE = 1'b1;
`else
  localparam bit POST_WRITE = 1'b0;
`endif

  localparam logic [3:0] GUARD_LAST   = 4'(GUARD_CYCLES - 1);
  localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [3:0]  guard_cnt_r, guard_cnt_s;
  logic [9:0]  to_cnt_r, to_cnt_s;
  logic        posted_r, posted_s;
  logic        err_pend_r, err_pend_s;
  logic        req_s;
  logic [24:0] addr_s;
  logic [15:0] din_s;
  logic [15:0] dat_s;
  logic [1:0]  wtbt_s;
  logic        rd_s, we_s, ack_s, err_s;

  // Next-state and next-output computation for every register in the block.
  always_comb begin
    state_s     = state_r;
    guard_cnt_s = guard_cnt_r;
    to_cnt_s    = to_cnt_r;
    posted_s    = posted_r;
    err_pend_s  = err_pend_r;
    addr_s      = mem_addr;
    din_s       = mem_din;
    wtbt_s      = mem_wtbt;
    dat_s       = wb_dat_o;
    rd_s        = mem_rd;
    we_s        = mem_we;
    ack_s       = 1'b0;
    err_s       = 1'b0;
    // a terminating pulse on the bus must not be mistaken for a new request
    req_s       = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;

    case (state_r)
      ST_IDLE: begin
        if (req_s && err_pend_r) begin
          err_s      = 1'b1;
          err_pend_s = 1'b0;
        end else if (req_s) begin
          addr_s = {wb_adr_i, 1'b0};
          din_s  = wb_dat_i;
          wtbt_s = wb_sel_i;
          if (wb_we_i && (wb_sel_i == 2'b00)) begin
            ack_s   = 1'b1;
            state_s = ST_ACK;
          end else begin
            we_s        = wb_we_i;
            rd_s        = ~wb_we_i;
            guard_cnt_s = 4'd0;
            to_cnt_s    = 10'd0;
            state_s     = ST_GUARD;
            if (POST_WRITE && wb_we_i) begin
              ack_s    = 1'b1;
              posted_s = 1'b1;
            end else begin
              posted_s = 1'b0;
            end
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GUARD: begin
        // the controller may still be showing ready from the previous access
        if (guard_cnt_r == GUARD_LAST) begin
          state_s = ST_WAIT;
        end else begin
          guard_cnt_s = guard_cnt_r + 4'd1;
        end
      end
      ST_WAIT: begin
        if (mem_ready) begin
          rd_s     = 1'b0;
          we_s     = 1'b0;
          state_s  = ST_ACK;
          ack_s    = wb_cyc_i & ~posted_r;
          posted_s = 1'b0;
          if (mem_rd) begin
            dat_s = mem_dout;
          end else begin
            dat_s = wb_dat_o;
          end
        end else if (to_cnt_r == TIMEOUT_LAST) begin
          rd_s     = 1'b0;
          we_s     = 1'b0;
          state_s  = ST_IDLE;
          posted_s = 1'b0;
          if (posted_r) begin
            err_pend_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          to_cnt_s = to_cnt_r + 10'd1;
        end
      end
      ST_ACK: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; init clears everything asynchronously.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state_r     <= ST_IDLE;
      guard_cnt_r <= 4'd0;
      to_cnt_r    <= 10'd0;
      posted_r    <= 1'b0;
      err_pend_r  <= 1'b0;
      mem_addr    <= 25'd0;
      mem_din     <= 16'd0;
      mem_wtbt    <= 2'b00;
      wb_dat_o    <= 16'd0;
      mem_rd      <= 1'b0;
      mem_we      <= 1'b0;
      wb_ack_o    <= 1'b0;
      wb_err_o    <= 1'b0;
    end else begin
      state_r     <= state_s;
      guard_cnt_r <= guard_cnt_s;
      to_cnt_r    <= to_cnt_s;
      posted_r    <= posted_s;
      err_pend_r  <= err_pend_s;
      mem_addr    <= addr_s;
      mem_din     <= din_s;
      mem_wtbt    <= wtbt_s;
      wb_dat_o    <= dat_s;
      mem_rd      <= rd_s;
      mem_we      <= we_s;
      wb_ack_o    <= ack_s;
      wb_err_o    <= err_s;
    end
  end

endmodule
